alu_exec_ctrl: RTL and testbench

- Multi-cycle execute controller that sits directly upstream of the 8-bit ALU and also consumes its outputs.
- Accepts one 16-bit instruction per handshake, reads operands from an internal 4x8 register file, and drives the ALU operand/opcode inputs.
- Captures the ALU result, writes it back to the destination register, and holds architectural carry/zero flags.
- Forms the execute/writeback core of the 8-bit processor.

---
 rtl/proc_pkg.sv | 36 +++
 rtl/regfile_4x8.sv | 37 +++
 rtl/alu_exec_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor execute core: opcodes,
// instruction field positions and the execute FSM encoding.
package proc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } exec_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADDI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// General register file: two combinational operand read ports, a debug
// read port and one synchronous write port; async reset clears every entry.
module regfile_4x8 #(
    parameter int NREGS = 4,
    parameter int DW    = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] dbg_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = regs[rd_addr];
    assign rs_data  = regs[rs_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute/writeback controller: accepts one instruction, drives the external
// ALU, captures its result and writes it back with the carry/zero flags.
module alu_exec_ctrl
    import proc_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [3:0]    alu_opcode,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_carry,
    input  logic          alu_zero,
    output logic          carry_flag,
    output logic          zero_flag,
    output logic          done,
    output logic          illegal,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    exec_state_t   state, state_nxt;
    logic [15:0]   ir;
    logic [3:0]    ir_op;
    logic [1:0]    ir_rd, ir_rs;
    logic [DW-1:0] ir_imm;
    logic [DW-1:0] rd_data, rs_data, op2_sel;
    logic [DW-1:0] res_q;
    logic          carry_q, zero_q;
    logic          accept, load_ops, capture, write_en, flag_illegal;

    assign ir_op  = ir[OPC_MSB:OPC_LSB];
    assign ir_rd  = ir[RD_MSB:RD_LSB];
    assign ir_rs  = ir[RS_MSB:RS_LSB];
    assign ir_imm = ir[IMM_MSB:IMM_LSB];

    assign instr_ready = (state == ST_IDLE) && !rst;

    regfile_4x8 #(.NREGS(NREGS), .DW(DW), .AW(2)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (ir_rd),
        .rs_addr  (ir_rs),
        .dbg_addr (dbg_addr),
        .rd_data  (rd_data),
        .rs_data  (rs_data),
        .dbg_data (dbg_data),
        .wr_en    (write_en),
        .wr_addr  (ir_rd),
        .wr_data  (res_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        load_ops     = 1'b0;
        capture      = 1'b0;
        write_en     = 1'b0;
        flag_illegal = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (is_legal_op(ir_op)) begin
                    load_ops  = 1'b1;
                    state_nxt = ST_EXEC;
                end else begin
                    flag_illegal = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                capture   = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                write_en  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOT has no second operand, so the ALU sees zero there
    always_comb begin
        op2_sel = rs_data;
        case (ir_op)
            OP_ADDI: op2_sel = ir_imm;
            OP_NOT:  op2_sel = '0;
            default: op2_sel = rs_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir         <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_opcode <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            done    <= write_en;
            illegal <= flag_illegal;
            if (accept) ir <= instr;
            if (load_ops) begin
                alu_opcode <= ir_op;
                alu_op1    <= rd_data;
                alu_op2    <= op2_sel;
            end
            if (capture) begin
                res_q   <= alu_result;
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
            end
            // flags are architectural: they move only as the result retires
            if (write_en) begin
                carry_flag <= carry_q;
                zero_flag  <= zero_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural 8-bit ALU beside it.
// Expected writebacks are queued at issue and compared at done/illegal.
module tb_alu_exec_ctrl;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [7:0]  alu_op1, alu_op2, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_carry, alu_zero;
    logic        carry_flag, zero_flag, done, illegal;
    logic [1:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
    logic [9:0]  alu_bits;

    typedef struct {
        bit         is_illegal;
        logic [1:0] rd;
        logic [7:0] value;
        bit         carry;
        bit         zero;
        int         acc;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    logic [7:0] mregs [4];
    bit         mcarry, mzero;
    int         cycle = 0;
    int         checks = 0;
    int         errors = 0;
    int         acc_a, acc_b;

    alu_exec_ctrl #(.NREGS(4), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // returns {zero, carry, result[7:0]}
    function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        s = '0;
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
            end
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            default: r = '0;
        endcase
        return {(r == 8'h00), c, r};
    endfunction

    always_comb alu_bits = alu_ref(alu_opcode, alu_op1, alu_op2);
    assign alu_result = alu_bits[7:0];
    assign alu_carry  = alu_bits[8];
    assign alu_zero   = alu_bits[9];

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ins, input bit hold, output int acc);
        int         waited;
        exp_t       e;
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] b;
        logic [9:0] res;
        acc = -1;
        @(negedge clk);
        waited = 0;
        while (!instr_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        instr       = ins;
        instr_valid = 1'b1;
        acc         = cycle + 1;
        op = ins[15:12];
        rd = ins[11:10];
        rs = ins[9:8];
        e.acc = acc;
        e.rd  = rd;
        if (op > OP_ADDI) begin
            e.is_illegal = 1'b1;
            e.value      = 8'h00;
            e.carry      = mcarry;
            e.zero       = mzero;
        end else begin
            b = (op == OP_ADDI) ? ins[7:0] : (op == OP_NOT) ? 8'h00 : mregs[rs];
            res = alu_ref(op, mregs[rd], b);
            mregs[rd]    = res[7:0];
            mcarry       = res[8];
            mzero        = res[9];
            e.is_illegal = 1'b0;
            e.value      = res[7:0];
            e.carry      = res[8];
            e.zero       = res[9];
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    // every done/illegal pulse must match the oldest outstanding instruction
    always @(negedge clk) begin
        if (!rst && (done || illegal)) begin
            if (sbq.size() == 0) begin
                checkOutput(done ? "unexpected_done" : "unexpected_illegal", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("flags", {carry_flag, zero_flag}, {mon_e.carry, mon_e.zero});
                if (mon_e.is_illegal) begin
                    checkOutput("illegal_pulse", {illegal, done}, 2'b10);
                    checkOutput("illegal_latency", cycle - mon_e.acc, 32'd1);
                end else begin
                    checkOutput("done_pulse", {illegal, done}, 2'b01);
                    checkOutput("done_latency", cycle - mon_e.acc, 32'd3);
                    dbg_addr = mon_e.rd;
                    #1;
                    checkOutput("wb_value", dbg_data, mon_e.value);
                end
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sbq.size() != 0) begin
            checkOutput("drain_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic checkRegs();
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checkOutput($sformatf("R%0d", i), dbg_data, mregs[i]);
        end
    endtask

    task automatic doReset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        #1;
        checkOutput("rst_ready", instr_ready, 32'd0);
        checkOutput("rst_outputs", {alu_op1, alu_op2, alu_opcode, carry_flag, zero_flag, done, illegal}, 32'd0);
        sbq.delete();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mcarry = 1'b0;
        mzero  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", instr_ready, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        #3;
        doReset();
        checkRegs();

        applyStimulus(mk(OP_ADDI, 2'd0, 2'd0, 8'h05), 1'b0, acc_a);
        applyStimulus(mk(OP_ADDI, 2'd1, 2'd0, 8'h03), 1'b0, acc_a);
        applyStimulus(mk(OP_ADD,  2'd0, 2'd1, 8'h00), 1'b0, acc_a);
        waitIdle();
        checkOutput("add_flags", {carry_flag, zero_flag}, 2'b00);

        applyStimulus(mk(OP_ADDI, 2'd2, 2'd0, 8'hFF), 1'b0, acc_a);
        applyStimulus(mk(OP_ADDI, 2'd2, 2'd0, 8'h01), 1'b0, acc_a);
        waitIdle();
        checkOutput("wrap_flags", {carry_flag, zero_flag}, 2'b11);
        applyStimulus(mk(OP_ADDI, 2'd3, 2'd0, 8'h02), 1'b0, acc_a);
        applyStimulus(mk(OP_SUB,  2'd3, 2'd0, 8'h00), 1'b0, acc_a);
        waitIdle();
        checkOutput("sub_flags", {carry_flag, zero_flag}, 2'b10);
        checkRegs();

        applyStimulus(mk(OP_XOR,  2'd1, 2'd1, 8'h00), 1'b0, acc_a);
        applyStimulus(mk(OP_ADDI, 2'd1, 2'd0, 8'h0F), 1'b0, acc_a);
        applyStimulus(mk(OP_XOR,  2'd1, 2'd1, 8'h00), 1'b0, acc_a);
        waitIdle();
        checkOutput("xor_flags", {carry_flag, zero_flag}, 2'b01);
        applyStimulus(mk(OP_NOT,  2'd1, 2'd2, 8'h00), 1'b0, acc_a);
        waitIdle();
        checkOutput("not_flags", {carry_flag, zero_flag}, 2'b00);

        applyStimulus(mk(4'b1010, 2'd0, 2'd1, 8'h55), 1'b1, acc_a);
        applyStimulus(mk(OP_ADDI, 2'd0, 2'd0, 8'h01), 1'b0, acc_b);
        checkOutput("illegal_reaccept", acc_b - acc_a, 32'd2);
        waitIdle();
        checkRegs();

        applyStimulus(mk(OP_ADDI, 2'd0, 2'd0, 8'h10), 1'b0, acc_a);
        applyStimulus(mk(OP_ADDI, 2'd1, 2'd0, 8'h20), 1'b0, acc_a);
        waitIdle();
        applyStimulus(mk(OP_ADD,  2'd0, 2'd1, 8'h00), 1'b0, acc_a);
        @(posedge clk);
        #3;
        doReset();
        repeat (4) @(negedge clk);
        checkRegs();
        applyStimulus(mk(OP_ADDI, 2'd0, 2'd0, 8'h10), 1'b0, acc_a);
        applyStimulus(mk(OP_ADDI, 2'd1, 2'd0, 8'h20), 1'b0, acc_a);
        applyStimulus(mk(OP_ADD,  2'd0, 2'd1, 8'h00), 1'b0, acc_a);
        waitIdle();
        checkRegs();

        for (int k = 0; k < 24; k++) begin
            applyStimulus(mk(4'($urandom_range(0, 8)), 2'($urandom_range(0, 3)),
                             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))),
                          1'($urandom_range(0, 1)), acc_a);
        end
        #1;
        instr_valid = 1'b0;
        waitIdle();
        checkRegs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
